// File: rtl/accumulate_main.sv
// -----------------------------------------------------------------------------
// accumulate_main
//
// Iterative accumulator kernel. A start strobe latches a starting index and a
// starting accumulator. The engine then adds every index value from the start
// up to LIMIT (inclusive) into the accumulator, one addition per clock. When
// the loop exits, the 64-bit sum is registered on `result` and `w_enable`
// pulses for exactly one cycle.
//
//   acc = init_acc; for (i = init_i; i <= LIMIT; i++) acc += i; result = acc;
//
// Parameters
//   LIMIT     inclusive upper bound of the loop index (unsigned, < 2^64-1)
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   r_enable  in   1   start strobe, sampled only while idle
//   init_i    in  64   starting loop index, latched on start
//   init_acc  in  64   starting accumulator value, latched on start
//   w_enable  out  1   done strobe, one cycle per completed run
//   result    out 64   final accumulator, held until the next completion
// -----------------------------------------------------------------------------
module accumulate_main #(
  parameter logic [63:0] LIMIT = 64'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_enable,
  input  logic [63:0] init_i,
  input  logic [63:0] init_acc,
  output logic        w_enable,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] i;
  logic [63:0] acc;

  // Single-process FSM: state, datapath and outputs are all registered here,
  // so w_enable and result never glitch.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values, regardless of statement order.
  // NOTE: every register, datapath included, is reset; a reset mid-run must
  // discard the partial sum so an aborted run can never surface as a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      acc      <= '0;
      result   <= '0;
      w_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Inputs matter only on this edge; later changes are ignored.
          if (r_enable) begin
            i     <= init_i;
            acc   <= init_acc;
            state <= LOOP;
          end
        end

        LOOP: begin
          // Unsigned compare. Because LIMIT < 2^64-1, i+1 cannot wrap while
          // the loop is still running, so the loop always terminates.
          if (i <= LIMIT) begin
            acc <= acc + i;   // modulo 2^64, no overflow flag
            i   <= i + 64'd1;
          end else begin
            result   <= acc;
            w_enable <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          // r_enable is not looked at here: no queuing of starts.
          w_enable <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          w_enable <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate_main.sv
// -----------------------------------------------------------------------------
// tb_accumulate_main
//
// Self-checking bench for accumulate_main with LIMIT = 10. A table of directed
// vectors {init_i, init_acc, expected result, expected start-to-done latency}
// is applied one run at a time; hand-written sequences then cover a reset
// abort mid-run and back-to-back runs with r_enable held high.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_accumulate_main;

  logic        clk;
  logic        rst_n;
  logic        r_enable;
  logic [63:0] init_i;
  logic [63:0] init_acc;
  logic        w_enable;
  logic [63:0] result;

  accumulate_main #(.LIMIT(64'd10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_enable (r_enable),
    .init_i   (init_i),
    .init_acc (init_acc),
    .w_enable (w_enable),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ii;
    logic [63:0] ia;
    logic [63:0] res;
    int          lat;
  } vec_t;

  localparam int NVEC   = 7;
  localparam int BUDGET = 40;

  vec_t        vecs [NVEC];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] exp_prev = 64'd0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One complete run from IDLE. Init inputs are scrambled right after the
  // start edge to show they are only sampled on that edge.
  task automatic run_vec(input vec_t v, input string tag);
    int c    = 0;
    bit seen = 1'b0;
    @(negedge clk);
    r_enable = 1'b1;
    init_i   = v.ii;
    init_acc = v.ia;
    @(posedge clk);                       // start edge N
    @(negedge clk);
    r_enable = 1'b0;
    init_i   = {$urandom, $urandom};
    init_acc = {$urandom, $urandom};
    while (c < BUDGET && !seen) begin
      @(negedge clk);
      c++;                                // now just after edge N+c
      if (c == 1 && v.lat > 1)
        check({tag, "_hold"}, result, exp_prev);
      if (w_enable) seen = 1'b1;
    end
    if (!seen) $display("FAIL %s_timeout: got no w_enable within %0d cycles, required one", tag, BUDGET);
    check({tag, "_latency"}, 64'(c), 64'(v.lat));
    check({tag, "_result"}, result, v.res);
    @(negedge clk);
    check({tag, "_pulse_width"}, {63'd0, w_enable}, 64'd0);
    check({tag, "_result_held"}, result, v.res);
    exp_prev = v.res;
  endtask

  initial begin
    vecs[0] = '{ii: 64'd0,  ia: 64'd0,                   res: 64'd55,      lat: 12};
    vecs[1] = '{ii: 64'd5,  ia: 64'd100,                 res: 64'd145,     lat: 7};
    vecs[2] = '{ii: 64'd11, ia: 64'h1234,                res: 64'h1234,    lat: 1};
    vecs[3] = '{ii: 64'd10, ia: 64'hFFFF_FFFF_FFFF_FFF6, res: 64'd0,       lat: 2};
    vecs[4] = '{ii: 64'hFFFF_FFFF_FFFF_FFFF, ia: 64'd7,  res: 64'd7,       lat: 1};
    vecs[5] = '{ii: 64'd10, ia: 64'd0,                   res: 64'd10,      lat: 2};
    vecs[6] = '{ii: 64'd3,  ia: 64'd5,                   res: 64'd57,      lat: 9};

    rst_n    = 1'b0;
    r_enable = 1'b0;
    init_i   = '0;
    init_acc = '0;
    #1;
    check("reset_w_enable", {63'd0, w_enable}, 64'd0);
    check("reset_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_w_enable", {63'd0, w_enable}, 64'd0);
    check("idle_result", result, 64'd0);

    for (int k = 0; k < NVEC; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // Abort: start (0,0), extra start pulse at cycle 4, reset at cycle 6.
    begin
      int highs = 0;
      @(negedge clk);
      r_enable = 1'b1;
      init_i   = 64'd0;
      init_acc = 64'd0;
      @(posedge clk);                     // start edge N
      @(negedge clk);
      r_enable = 1'b0;
      repeat (3) @(negedge clk);          // after edge N+3
      r_enable = 1'b1;                    // sampled at N+4, must be ignored
      @(negedge clk);
      r_enable = 1'b0;
      @(negedge clk);                     // after edge N+5
      check("abort_result_before", result, exp_prev);
      rst_n = 1'b0;
      #1;
      check("abort_w_enable", {63'd0, w_enable}, 64'd0);
      check("abort_result", result, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (w_enable) highs++;
      end
      check("abort_no_done", 64'(highs), 64'd0);
      exp_prev = 64'd0;
      run_vec(vecs[0], "after_abort");
    end

    // r_enable held high: a new run starts on each return to IDLE.
    begin
      int  pulses    = 0;
      int  last      = -1;
      bit  prev_high = 1'b0;
      @(negedge clk);
      r_enable = 1'b1;
      init_i   = 64'd0;
      init_acc = 64'd0;
      @(posedge clk);                     // start edge N
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);                   // c = 0 is just after edge N
        if (w_enable) begin
          check("held_result", result, 64'd55);
          check("held_consecutive", {63'd0, prev_high}, 64'd0);
          if (last < 0) check("held_first", 64'(c), 64'd12);
          else          check("held_interval", 64'(c - last), 64'd14);
          last = c;
          pulses++;
        end
        prev_high = w_enable;
      end
      check("held_pulse_count", 64'(pulses), 64'd4);
      r_enable = 1'b0;
      repeat (20) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case a sequence above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
